// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the handshaked data memory:
//   - load/store type encodings as seen on load_type_i / store_type_i
//   - the controller state enum
//   - is_aligned(): decides whether an access may be performed at an address
package dmem_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LBU = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LW  = 3'b100;

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Halfwords need an even address, words a multiple of four. Load codes
    // 101-111 fall into the default arm and are checked like LW. A "no write"
    // store touches nothing, so it can never be misaligned.
    function automatic logic is_aligned(input logic       we,
                                        input logic [2:0] load_type,
                                        input logic [1:0] store_type,
                                        input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        if (we) begin
            case (store_type)
                ST_SH:   ok = ~addr_lo[0];
                ST_SW:   ok = (addr_lo == 2'b00);
                default: ok = 1'b1;
            endcase
        end else begin
            case (load_type)
                LD_LB, LD_LBU: ok = 1'b1;
                LD_LH, LD_LHU: ok = ~addr_lo[0];
                default:       ok = (addr_lo == 2'b00);
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Byte-addressed storage of 2^ADDR_W bytes, little-endian.
// Ports:
//   clk    rising-edge clock for writes
//   we     write strobe
//   be     byte enables; be[k] writes byte k of wdata to addr+k
//   addr   byte address of the access
//   wdata  write data, byte k in wdata[8k+7:8k]
//   rdata  asynchronous read of bytes addr+3..addr
// Contents are never reset.
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Byte lane addresses. Aligned halfword/word accesses never cross the top
    // of memory; a byte access near the top only wraps in the unused lanes.
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    assign a0 = addr;
    assign a1 = addr + ADDR_W'(1);
    assign a2 = addr + ADDR_W'(2);
    assign a3 = addr + ADDR_W'(3);

    assign rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[a0] <= wdata[7:0];
            if (be[1]) mem[a1] <= wdata[15:8];
            if (be[2]) mem[a2] <= wdata[23:16];
            if (be[3]) mem[a3] <= wdata[31:24];
        end
    end

endmodule

// File: rtl/data_mem_wait.sv
// data_mem_wait
// Handshaked byte-addressed data memory with WAIT_CYCLES wait states.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_i, ready_o  request handshake; accept on req_i && ready_o
//   we_i            1 = store, 0 = load
//   addr_i          byte address
//   wr_data_i       store data (low byte/halfword for SB/SH)
//   load_type_i     LB/LBU/LH/LHU/LW (101-111 act as LW)
//   store_type_i    SB/SH/SW/none
//   rsp_valid_o     one-cycle response strobe
//   rd_data_o       extended load data, 0 for stores and misaligned accesses
//   misalign_o      misaligned-access flag, valid with rsp_valid_o
module data_mem_wait #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [2:0]        load_type_i,
    input  logic [1:0]        store_type_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rd_data_o,
    output logic              misalign_o
);
    import dmem_pkg::*;

    state_t            state, next_state;
    logic [3:0]        cnt, next_cnt;

    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [31:0]       hold_wdata;
    logic [2:0]        hold_ltype;
    logic [1:0]        hold_stype;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_ltype;
    logic [1:0]        cur_stype;

    logic              accept;
    logic              aligned;
    logic              enter_resp;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic [31:0]       ext_data;

    // ready is masked while reset is held so nothing is accepted until release
    assign ready_o     = (state == IDLE) && rst_n;
    assign accept      = req_i && ready_o;
    assign rsp_valid_o = (state == RESP);

    // With zero wait states the commit edge is the accept edge itself, so the
    // access is taken straight from the inputs while idle and from the
    // captured copy otherwise.
    assign cur_we    = (state == IDLE) ? we_i         : hold_we;
    assign cur_addr  = (state == IDLE) ? addr_i       : hold_addr;
    assign cur_wdata = (state == IDLE) ? wr_data_i    : hold_wdata;
    assign cur_ltype = (state == IDLE) ? load_type_i  : hold_ltype;
    assign cur_stype = (state == IDLE) ? store_type_i : hold_stype;

    assign aligned    = is_aligned(cur_we, cur_ltype, cur_stype, cur_addr[1:0]);
    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign mem_we     = enter_resp && cur_we && aligned && (cur_stype != ST_NONE);

    // Byte enables relative to the access address
    always_comb begin
        mem_be = 4'b0000;
        case (cur_stype)
            ST_SB:   mem_be = 4'b0001;
            ST_SH:   mem_be = 4'b0011;
            ST_SW:   mem_be = 4'b1111;
            default: mem_be = 4'b0000;
        endcase
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (cur_addr),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // Sign/zero extension of the addressed byte or halfword
    always_comb begin
        ext_data = mem_rdata;
        case (cur_ltype)
            LD_LB:   ext_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            LD_LBU:  ext_data = {24'd0, mem_rdata[7:0]};
            LD_LH:   ext_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            LD_LHU:  ext_data = {16'd0, mem_rdata[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    // Next-state and wait-counter logic
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= 32'd0;
            hold_ltype <= 3'd0;
            hold_stype <= 2'd0;
        end else if (accept) begin
            hold_we    <= we_i;
            hold_addr  <= addr_i;
            hold_wdata <= wr_data_i;
            hold_ltype <= load_type_i;
            hold_stype <= store_type_i;
        end
    end

    // Response registers load on the commit edge and hold until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o  <= 32'd0;
            misalign_o <= 1'b0;
        end else if (enter_resp) begin
            rd_data_o  <= (!cur_we && aligned) ? ext_data : 32'd0;
            misalign_o <= ~aligned;
        end
    end

endmodule

// File: tb/tb_data_mem_wait.sv
// tb_data_mem_wait
// Scoreboard bench for data_mem_wait. The stimulus tasks push the expected
// response of each request into exp_q; the monitor pops and compares on every
// rsp_valid_o, also checking the accept-to-response latency. A second
// instance with WAIT_CYCLES=0 is exercised directly.
module tb_data_mem_wait;
    import dmem_pkg::*;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_i, we_i, ready_o, rsp_valid_o, misalign_o;
    logic [9:0]  addr_i;
    logic [31:0] wr_data_i, rd_data_o;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;

    logic        req0, we0, ready0, rsp0, mis0;
    logic [9:0]  addr0;
    logic [31:0] wdata0, rdata0;
    logic [2:0]  ltype0;
    logic [1:0]  stype0;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cycle     = 0;
    int   checks    = 0;
    int   fails     = 0;
    int   rsp_count = 0;

    always #5 clk = ~clk;

    data_mem_wait #(
        .ADDR_W      (10),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .ready_o      (ready_o),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wr_data_i    (wr_data_i),
        .load_type_i  (load_type_i),
        .store_type_i (store_type_i),
        .rsp_valid_o  (rsp_valid_o),
        .rd_data_o    (rd_data_o),
        .misalign_o   (misalign_o)
    );

    data_mem_wait #(
        .ADDR_W      (10),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req0),
        .ready_o      (ready0),
        .we_i         (we0),
        .addr_i       (addr0),
        .wr_data_i    (wdata0),
        .load_type_i  (ltype0),
        .store_type_i (stype0),
        .rsp_valid_o  (rsp0),
        .rd_data_o    (rdata0),
        .misalign_o   (mis0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: records accepts, and checks each response against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        cycle++;
        if (!rst_n) begin
            acc_q.delete();
        end else begin
            if (req_i && ready_o) acc_q.push_back(cycle);
            if (rsp_valid_o) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected response", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.name, " data"}, rd_data_o, e.data);
                    checkOutput({e.name, " misalign"}, 32'(misalign_o), 32'(e.mis));
                    lat = (acc_q.size() > 0) ? cycle - acc_q.pop_front() : -1;
                    checkOutput({e.name, " latency"}, 32'(lat), 32'(WC + 1));
                end
            end
        end
    end

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput({name, " response timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic applyStimulus(input string name, input logic we, input logic [9:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] ltype,
                                 input logic [1:0] stype, input logic [31:0] exp_data,
                                 input logic exp_mis);
        int n;
        exp_q.push_back('{data: exp_data, mis: exp_mis, name: name});
        @(posedge clk); #1;
        n = 0;
        while (!ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) checkOutput({name, " ready timeout"}, 32'(ready_o), 32'd1);
        req_i        = 1'b1;
        we_i         = we;
        addr_i       = addr;
        wr_data_i    = wdata;
        load_type_i  = ltype;
        store_type_i = stype;
        @(posedge clk); #1;
        req_i = 1'b0;
        waitIdle(name);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        rst_n        = 1'b0;
        req_i        = 1'b0;
        we_i         = 1'b0;
        addr_i       = '0;
        wr_data_i    = '0;
        load_type_i  = LD_LW;
        store_type_i = ST_NONE;
        req0         = 1'b0;
        we0          = 1'b0;
        addr0        = '0;
        wdata0       = '0;
        ltype0       = LD_LW;
        stype0       = ST_NONE;

        #1;
        checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset rd_data", rd_data_o, 32'd0);
        checkOutput("reset misalign", 32'(misalign_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset", 32'(ready_o), 32'd1);

        // Word store/load and extension
        applyStimulus("SW 0x010", 1'b1, 10'h010, 32'hDEADBEEF, LD_LW, ST_SW, 32'h0, 1'b0);
        applyStimulus("LW 0x010", 1'b0, 10'h010, 32'h0, LD_LW, ST_NONE, 32'hDEADBEEF, 1'b0);
        applyStimulus("LB 0x013", 1'b0, 10'h013, 32'h0, LD_LB, ST_NONE, 32'hFFFFFFDE, 1'b0);
        applyStimulus("LBU 0x013", 1'b0, 10'h013, 32'h0, LD_LBU, ST_NONE, 32'h000000DE, 1'b0);
        applyStimulus("LH 0x012", 1'b0, 10'h012, 32'h0, LD_LH, ST_NONE, 32'hFFFFDEAD, 1'b0);
        applyStimulus("LHU 0x010", 1'b0, 10'h010, 32'h0, LD_LHU, ST_NONE, 32'h0000BEEF, 1'b0);

        // Misaligned accesses do nothing and flag the error
        applyStimulus("SH 0x011", 1'b1, 10'h011, 32'h00001234, LD_LW, ST_SH, 32'h0, 1'b1);
        applyStimulus("LW 0x010 after SH", 1'b0, 10'h010, 32'h0, LD_LW, ST_NONE, 32'hDEADBEEF, 1'b0);
        applyStimulus("LW 0x012", 1'b0, 10'h012, 32'h0, LD_LW, ST_NONE, 32'h0, 1'b1);

        // Byte store, no-write store, default-LW encoding
        applyStimulus("SB 0x010", 1'b1, 10'h010, 32'h12345655, LD_LW, ST_SB, 32'h0, 1'b0);
        applyStimulus("LW 0x010 after SB", 1'b0, 10'h010, 32'h0, LD_LW, ST_NONE, 32'hDEADBE55, 1'b0);
        applyStimulus("ST_NONE 0x010", 1'b1, 10'h010, 32'hFFFFFFFF, LD_LW, ST_NONE, 32'h0, 1'b0);
        applyStimulus("LW 0x010 after ST_NONE", 1'b0, 10'h010, 32'h0, LD_LW, ST_NONE, 32'hDEADBE55, 1'b0);
        applyStimulus("load type 111", 1'b0, 10'h010, 32'h0, 3'b111, ST_NONE, 32'hDEADBE55, 1'b0);
        applyStimulus("LB 0x010", 1'b0, 10'h010, 32'h0, LD_LB, ST_NONE, 32'h00000055, 1'b0);

        // req_i held high: one accept every WC+2 cycles, ready low otherwise
        base = rsp_count;
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{data: 32'hDEADBE55, mis: 1'b0, name: $sformatf("hold LW #%0d", k)});
        @(posedge clk); #1;
        req_i       = 1'b1;
        we_i        = 1'b0;
        addr_i      = 10'h010;
        load_type_i = LD_LW;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold ready cycle %0d", i), 32'(ready_o),
                        (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        req_i = 1'b0;
        waitIdle("hold");
        repeat (3) @(negedge clk);
        checkOutput("hold response count", 32'(rsp_count - base), 32'd3);

        // Zero wait states: response in the cycle right after the accept edge
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'h004; wdata0 = 32'hCAFEF00D; stype0 = ST_SW;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("WC0 SW rsp_valid", 32'(rsp0), 32'd1);
        checkOutput("WC0 ready in RESP", 32'(ready0), 32'd0);
        checkOutput("WC0 SW rd_data", rdata0, 32'd0);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; ltype0 = LD_LW; stype0 = ST_NONE;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("WC0 LW rsp_valid", 32'(rsp0), 32'd1);
        checkOutput("WC0 LW rd_data", rdata0, 32'hCAFEF00D);
        checkOutput("WC0 LW misalign", 32'(mis0), 32'd0);
        @(negedge clk);
        checkOutput("WC0 strobe one cycle", 32'(rsp0), 32'd0);

        // Reset while a store waits: store is dropped, outputs clear at once
        applyStimulus("SW 0x020 setup", 1'b1, 10'h020, 32'h11111111, LD_LW, ST_SW, 32'h0, 1'b0);
        applyStimulus("LW 0x020 setup", 1'b0, 10'h020, 32'h0, LD_LW, ST_NONE, 32'h11111111, 1'b0);
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b1; addr_i = 10'h020; wr_data_i = 32'h22222222; store_type_i = ST_SW;
        @(posedge clk); #1;
        req_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("async reset rd_data", rd_data_o, 32'd0);
        checkOutput("async reset misalign", 32'(misalign_o), 32'd0);
        checkOutput("async reset WC0 rd_data", rdata0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready after reset release", 32'(ready_o), 32'd1);
        applyStimulus("LW 0x020 after reset", 1'b0, 10'h020, 32'h0, LD_LW, ST_NONE, 32'h11111111, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
